fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the RV32I core: owns the program counter, issues one instruction-memory read at a time, and presents the fetched word with its PC to the control/decode stage (`out_opcode` drives the control unit opcode input directly). Taken branches and jumps resolved downstream redirect the PC and squash any in-flight or held fetch. The stage is a small FSM with a single-entry output register and decode back-pressure.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `NOP_INST`, 32'h0000_0013, `out_inst` value after reset (addi x0,x0,0)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  32  byte address of request (= `pc`)
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  read data valid (≥1 cycle after acceptance)
- `imem_rdata`  in  32  instruction word
- `redirect`  in  1  taken branch/jump from execute
- `redirect_pc`  in  32  target address
- `out_valid`  out  1  `out_inst`/`out_pc` valid for decode
- `out_ready`  in  1  decode consumes held instruction
- `out_inst`  out  32  fetched instruction
- `out_pc`  out  32  address of `out_inst`
- `out_opcode`  out  7  `out_inst[6:0]`, combinational

## Operation
- States: REQ, WAIT, HOLD, DROP. Reset → REQ, `pc`=`RESET_PC`, `out_valid`=0, `out_inst`=`NOP_INST`, `out_pc`=0.
- `imem_req` = (state==REQ) & ~`reset`; `imem_addr` = `pc` always.
- REQ: `imem_ready` → WAIT; else stay, request held with stable address.
- WAIT: `imem_rvalid` → capture `out_inst`←`imem_rdata`, `out_pc`←`pc`, `out_valid`←1, `pc`←`pc`+4, → HOLD.
- HOLD: `out_valid`=1; `out_ready` → `out_valid`←0, → REQ. Outputs stable while held.
- DROP: wait for `imem_rvalid`, discard data, → REQ.
- Redirect (priority over all above): `pc`←{`redirect_pc[31:2]`,2'b00}, `out_valid`←0, `out_inst`←`NOP_INST`; next state: REQ without `imem_ready` → REQ; REQ with `imem_ready` → DROP; WAIT with `imem_rvalid` → REQ (data discarded); WAIT without → DROP; HOLD → REQ; DROP with `imem_rvalid` → REQ; DROP without → DROP.
- At most one outstanding memory request ever. `imem_rvalid` outside WAIT/DROP is ignored.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 → 32'h0000_0000.

## Timing
- Request accepted at edge N → earliest `imem_rvalid` at N+1 → `out_valid` high from N+2.
- Minimum 3 cycles per instruction (REQ, WAIT, HOLD) with single-cycle memory and `out_ready`=1.
- Redirect at edge N: `out_valid`=0 and `imem_addr`=target after N; new request visible cycle N+1 unless in DROP.
- Reset asserted mid-fetch: all state reinitialised next edge; pending response after reset lands in REQ and is ignored.

## Structure
- Shared package `rv32i_pkg`: fetch state enum, `NOP_INST`, opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH) shared with the control unit.
- Single module; no sub-module needed (PC register and FSM are one always block each).

## Test plan
- Reset, 1-cycle memory returning 0x00500093 @0 → `out_valid` at cycle 3, `out_inst`=0x00500093, `out_pc`=0, next `imem_addr`=4.
- `out_ready`=0 for 5 cycles in HOLD → outputs stable, `imem_req`=0, no PC advance; release → one request for addr 4.
- Redirect to 0x100 while in WAIT, response arrives 2 cycles later → response discarded (DROP), next request addr 0x100, `out_valid` never shows stale word.
- Redirect to 0x203 coinciding with `imem_ready` → state DROP, next request addr 0x200.
- PC=0xFFFFFFFC fetch → next `imem_addr`=0x00000000.
- Reset asserted in WAIT with `imem_rvalid` same cycle → `out_valid`=0, `out_inst`=0x00000013, `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: fetch FSM states, the canonical NOP and the
// major opcodes decoded by the control unit.
package rv32i_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2,
        FETCH_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem read in flight at most,
// and holds the fetched word for decode until it is consumed or squashed.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_inst,
    output logic [XLEN-1:0]    out_pc,
    output logic [OPC_W-1:0]   out_opcode
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [XLEN-1:0]    r_pc;
    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_inst;
    logic [XLEN-1:0]    r_out_pc;
    logic [XLEN-1:0]    w_redirect_pc;
    logic               w_capture;
    logic               w_unused_lsbs;

    // Branch targets are word aligned; the low bits from execute are dropped.
    assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_lsbs = &{1'b0, redirect_pc[1:0]};
    assign w_capture     = (r_state == FETCH_WAIT) && imem_rvalid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; a redirect must still account for a request already accepted
    always_comb begin
        w_state_nxt = r_state;
        if (redirect) begin
            unique case (r_state)
                FETCH_REQ:  w_state_nxt = imem_ready  ? FETCH_DROP : FETCH_REQ;
                FETCH_WAIT: w_state_nxt = imem_rvalid ? FETCH_REQ  : FETCH_DROP;
                FETCH_HOLD: w_state_nxt = FETCH_REQ;
                FETCH_DROP: w_state_nxt = imem_rvalid ? FETCH_REQ  : FETCH_DROP;
                default:    w_state_nxt = FETCH_REQ;
            endcase
        end else begin
            unique case (r_state)
                FETCH_REQ:  if (imem_ready)  w_state_nxt = FETCH_WAIT;
                FETCH_WAIT: if (imem_rvalid) w_state_nxt = FETCH_HOLD;
                FETCH_HOLD: if (out_ready)   w_state_nxt = FETCH_REQ;
                FETCH_DROP: if (imem_rvalid) w_state_nxt = FETCH_REQ;
                default:    w_state_nxt = FETCH_REQ;
            endcase
        end
    end

    // PC and decode output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_inst  <= NOP_INST;
            r_out_pc    <= '0;
        end else if (redirect) begin
            r_pc        <= w_redirect_pc;
            r_out_valid <= 1'b0;
            r_out_inst  <= NOP_INST;
        end else if (w_capture) begin
            r_pc        <= r_pc + XLEN'(4);
            r_out_valid <= 1'b1;
            r_out_inst  <= imem_rdata;
            r_out_pc    <= r_pc;
        end else if ((r_state == FETCH_HOLD) && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign imem_req   = (r_state == FETCH_REQ) && !reset;
    assign imem_addr  = r_pc;
    assign out_valid  = r_out_valid;
    assign out_inst   = r_out_inst;
    assign out_pc     = r_out_pc;
    assign out_opcode = r_out_inst[OPC_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: drives imem/decode/redirect cycle by cycle and
// checks outputs 1ns after each rising edge against hand-derived values.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;

    int errors = 0;
    int checks = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b1;

        // Reset state
        tick();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_inst",  out_inst,       32'h0000_0013);
        chk("rst_pc",    out_pc,         32'h0);
        chk("rst_addr",  imem_addr,      32'h0);
        chk("rst_req",   32'(imem_req),  32'h0);
        reset = 1'b0;
        #1;
        chk("req_after_rst", 32'(imem_req), 32'h1);

        // First fetch from address 0 with a single-cycle memory
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("wait_req",   32'(imem_req),  32'h0);
        chk("wait_valid", 32'(out_valid), 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        out_ready   = 1'b0;
        tick();
        chk("f0_valid",  32'(out_valid),  32'h1);
        chk("f0_inst",   out_inst,        32'h0050_0093);
        chk("f0_pc",     out_pc,          32'h0);
        chk("f0_addr",   imem_addr,       32'h4);
        chk("f0_opcode", 32'(out_opcode), 32'h13);
        chk("f0_req",    32'(imem_req),   32'h0);

        // Back-pressure: held outputs stable; spurious rvalid ignored
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'h1);
            chk("hold_inst",  out_inst,       32'h0050_0093);
            chk("hold_pc",    out_pc,         32'h0);
            chk("hold_addr",  imem_addr,      32'h4);
            chk("hold_req",   32'(imem_req),  32'h0);
        end
        imem_rvalid = 1'b0;
        out_ready   = 1'b1;
        tick();
        chk("rel_valid", 32'(out_valid), 32'h0);
        chk("rel_req",   32'(imem_req),  32'h1);
        chk("rel_addr",  imem_addr,      32'h4);
        tick();
        chk("stall_req",  32'(imem_req), 32'h1);
        chk("stall_addr", imem_addr,     32'h4);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("f1_wait_req", 32'(imem_req), 32'h0);

        // Redirect to 0x100 while waiting; late response must be dropped
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        chk("rdw_addr",  imem_addr,      32'h100);
        chk("rdw_req",   32'(imem_req),  32'h0);
        chk("rdw_valid", 32'(out_valid), 32'h0);
        tick();
        chk("drop_req",   32'(imem_req),  32'h0);
        chk("drop_valid", 32'(out_valid), 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        tick();
        imem_rvalid = 1'b0;
        chk("drop_done_valid", 32'(out_valid), 32'h0);
        chk("drop_done_inst",  out_inst,       32'h0000_0013);
        chk("drop_done_req",   32'(imem_req),  32'h1);
        chk("drop_done_addr",  imem_addr,      32'h100);

        // Fetch at 0x100
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_8067;
        tick();
        imem_rvalid = 1'b0;
        chk("f2_valid",  32'(out_valid),  32'h1);
        chk("f2_inst",   out_inst,        32'h0000_8067);
        chk("f2_pc",     out_pc,          32'h100);
        chk("f2_addr",   imem_addr,       32'h104);
        chk("f2_opcode", 32'(out_opcode), 32'h67);
        tick();
        chk("f2_cons_valid", 32'(out_valid), 32'h0);
        chk("f2_cons_req",   32'(imem_req),  32'h1);

        // Redirect to 0x203 in the same cycle the request is accepted
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        imem_ready  = 1'b1;
        tick();
        redirect   = 1'b0;
        imem_ready = 1'b0;
        chk("rdr_req",   32'(imem_req),  32'h0);
        chk("rdr_addr",  imem_addr,      32'h200);
        chk("rdr_valid", 32'(out_valid), 32'h0);
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        chk("rdr_done_req",  32'(imem_req), 32'h1);
        chk("rdr_done_addr", imem_addr,     32'h200);

        // PC wrap-around from 0xFFFFFFFC
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_req",  32'(imem_req), 32'h1);
        chk("wrap_addr", imem_addr,     32'hFFFF_FFFC);
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0033;
        tick();
        imem_rvalid = 1'b0;
        chk("wrap_pc",     out_pc,          32'hFFFF_FFFC);
        chk("wrap_next",   imem_addr,       32'h0);
        chk("wrap_inst",   out_inst,        32'h0000_0033);
        chk("wrap_opcode", 32'(out_opcode), 32'h33);
        tick();
        chk("wrap_cons_req", 32'(imem_req), 32'h1);

        // Reset mid-fetch with a response in the same cycle
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        chk("mrst_valid", 32'(out_valid), 32'h0);
        chk("mrst_inst",  out_inst,       32'h0000_0013);
        chk("mrst_addr",  imem_addr,      32'h0);
        chk("mrst_req",   32'(imem_req),  32'h0);
        reset = 1'b0;
        tick();
        imem_rvalid = 1'b0;
        chk("post_valid", 32'(out_valid), 32'h0);
        chk("post_inst",  out_inst,       32'h0000_0013);
        chk("post_req",   32'(imem_req),  32'h1);
        chk("post_addr",  imem_addr,      32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
